fb_copy_dma: RTL and testbench

Frame-snapshot DMA between the Minx CPU bus and the display-side framebuffer RAM. On each `frame_complete` pulse from `minx`, it requests the CPU bus and streams the 768-byte LCD framebuffer window (0x1000–0x12FF) into a dual-port display RAM, one byte per granted cycle. The scan-out logic reads a stable image from that RAM while the CPU renders the next frame.

---
 rtl/fb_copy_dma.sv | 172 +++++++++++++++++
 tb/tb_fb_copy_dma.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_copy_dma.sv
// Frame-snapshot DMA: copies the CPU-side LCD framebuffer window into display RAM once per frame.
// Optional double buffering (bank swap on completion) is enabled by defining FB_COPY_DOUBLE_BUFFER_EN.
module fb_copy_dma #(
    parameter logic [23:0] FB_BASE  = 24'h001000,
    parameter int          FB_BYTES = 768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_complete,
    output logic        bus_request,
    input  logic        bus_ack,
    output logic [23:0] mem_address,
    input  logic [7:0]  mem_data_in,
    output logic [10:0] dst_address,
    output logic [7:0]  dst_data,
    output logic        dst_we,
    output logic        display_bank,
    output logic        busy,
    output logic        copy_done,
    output logic [7:0]  frames_dropped
);

    // state  | meaning
    // IDLE   | waiting for a snapshot request
    // REQ    | bus requested, waiting for the first grant
    // STREAM | issuing reads and writing returned bytes
    // DONE   | one-cycle completion, indices cleared, bank swapped
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        STREAM,
        DONE
    } state_t;

    localparam logic [9:0] LAST_IDX = 10'(FB_BYTES - 1);

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic [9:0]  rd_idx_q, rd_idx_d;
    logic        rd_all_q, rd_all_d;
    logic [9:0]  wr_idx_q, wr_idx_d;
    logic        issue_q, issue_d;
    logic [7:0]  dropped_q, dropped_d;
    logic        write_bank;

    logic        issue;
    logic        consume;
    logic        drop;
    logic        last_write;

`ifdef FB_COPY_DOUBLE_BUFFER_EN
    logic        display_bank_q, display_bank_d;

    always_comb begin
        display_bank_d = display_bank_q;
        if (state_q == DONE) begin
            display_bank_d = ~display_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display_bank_q <= 1'b0;
        end else begin
            display_bank_q <= display_bank_d;
        end
    end

    assign display_bank = display_bank_q;
    assign write_bank   = ~display_bank_q;
`else
    assign display_bank = 1'b0;
    assign write_bank   = 1'b0;
`endif

    // rd_all_q marks that the final byte was issued, so rd_idx never needs to count past the window
    assign issue      = (state_q == STREAM) && bus_ack && !rd_all_q;
    assign last_write = issue_q && (wr_idx_q == LAST_IDX);

    // A request arriving in the same cycle IDLE consumes an older one stays queued
    assign consume = (state_q == IDLE) && (pending_q || frame_complete);
    assign drop    = frame_complete && pending_q && !consume;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        rd_idx_d  = rd_idx_q;
        rd_all_d  = rd_all_q;
        wr_idx_d  = wr_idx_q;
        issue_d   = issue;
        dropped_d = dropped_q;

        if (consume) begin
            pending_d = pending_q && frame_complete;
        end else if (frame_complete) begin
            pending_d = 1'b1;
        end

        if (drop && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end

        if (issue) begin
            if (rd_idx_q == LAST_IDX) begin
                rd_all_d = 1'b1;
            end else begin
                rd_idx_d = rd_idx_q + 10'd1;
            end
        end

        if (issue_q && !last_write) begin
            wr_idx_d = wr_idx_q + 10'd1;
        end

        case (state_q)
            IDLE: begin
                if (consume) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus_ack) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_write) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rd_idx_d = '0;
                rd_all_d = 1'b0;
                wr_idx_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_all_q  <= 1'b0;
            wr_idx_q  <= '0;
            issue_q   <= 1'b0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            rd_idx_q  <= rd_idx_d;
            rd_all_q  <= rd_all_d;
            wr_idx_q  <= wr_idx_d;
            issue_q   <= issue_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus_request    = (state_q == REQ) || (state_q == STREAM);
    assign busy           = bus_request;
    assign copy_done      = (state_q == DONE);
    assign mem_address    = FB_BASE + {14'd0, rd_idx_q};
    assign dst_we         = issue_q;
    assign dst_data       = issue_q ? mem_data_in : 8'd0;
    assign dst_address    = issue_q ? {write_bank, wr_idx_q} : 11'd0;
    assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_fb_copy_dma.sv
// Scoreboard bench for fb_copy_dma: expected display-RAM writes are queued per copy and
// popped by an independent monitor; timing and counters are checked inline.
module tb_fb_copy_dma;

    localparam logic [23:0] FB_BASE  = 24'h001000;
    localparam int          FB_BYTES = 768;
`ifdef FB_COPY_DOUBLE_BUFFER_EN
    localparam bit DB = 1'b1;
`else
    localparam bit DB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_complete = 1'b0;
    logic        bus_request;
    logic        bus_ack = 1'b0;
    logic [23:0] mem_address;
    logic [7:0]  mem_data_in = 8'd0;
    logic [10:0] dst_address;
    logic [7:0]  dst_data;
    logic        dst_we;
    logic        display_bank;
    logic        busy;
    logic        copy_done;
    logic [7:0]  frames_dropped;

    fb_copy_dma #(.FB_BASE(FB_BASE), .FB_BYTES(FB_BYTES)) dut (
        .clk(clk), .reset(reset), .frame_complete(frame_complete),
        .bus_request(bus_request), .bus_ack(bus_ack), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .dst_address(dst_address), .dst_data(dst_data),
        .dst_we(dst_we), .display_bank(display_bank), .busy(busy),
        .copy_done(copy_done), .frames_dropped(frames_dropped)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          wr_count = 0;
    logic [7:0]  key = 8'h5A;
    logic        wb_next = DB;
    logic        disp_exp = 1'b0;
    logic [18:0] exp_q[$];
    logic [23:0] addr_s = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // CPU memory: byte at offset k holds k[7:0] ^ key, returned one cycle after the address
    function automatic logic [7:0] mem_fn(input logic [23:0] a);
        logic [23:0] k;
        k = a - FB_BASE;
        return k[7:0] ^ key;
    endfunction

    always @(negedge clk) addr_s = mem_address;
    always @(posedge clk) begin
        #1 mem_data_in = mem_fn(addr_s);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every display-RAM write must match the head of the expected queue
    always @(negedge clk) begin
        if (dst_we === 1'b1) begin
            wr_count++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", dst_address, dst_data);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({dst_address, dst_data} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr %0h data %0h expected addr %0h data %0h",
                             dst_address, dst_data, e[18:8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_copy(input int n);
        for (int k = 0; k < n; k++) begin
            logic [9:0] kk;
            logic [7:0] kb;
            kk = 10'(k);
            kb = 8'(k);
            exp_q.push_back({wb_next, kk, kb ^ key});
        end
        if (n == FB_BYTES && DB) wb_next = ~wb_next;
    endtask

    task automatic pulse_fc();
        frame_complete = 1'b1;
        tick();
        frame_complete = 1'b0;
    endtask

    task automatic wait_done(input string nm, output int d);
        int t;
        t = 0;
        d = -1;
        while (t < 3000) begin
            tick();
            t++;
            if (copy_done === 1'b1) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_timeout: got no copy_done expected one within 3000 cycles", nm);
        end
    endtask

    task automatic after_done(input string nm);
        if (DB) disp_exp = ~disp_exp;
        tick();
        chk({nm, "_bank"}, display_bank, disp_exp);
        chk({nm, "_done_pulse"}, copy_done, 1'b0);
    endtask

    initial begin
        int a, d, w0;

        tick();
        tick();
        chk("rst_bus_request", bus_request, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dst_we", dst_we, 0);
        chk("rst_copy_done", copy_done, 0);
        chk("rst_mem_address", mem_address, FB_BASE);
        chk("rst_dst_address", dst_address, 0);
        chk("rst_dst_data", dst_data, 0);
        chk("rst_dropped", frames_dropped, 0);
        chk("rst_bank", display_bank, 0);
        reset = 1'b0;
        tick();

        // basic copy
        key = 8'h5A;
        w0 = wr_count;
        push_copy(FB_BYTES);
        pulse_fc();
        chk("req_after_fc", bus_request, 1);
        chk("busy_after_fc", busy, 1);
        bus_ack = 1'b1;
        a = cyc;
        wait_done("basic", d);
        chk("basic_latency", d - a, FB_BYTES + 2);
        chk("basic_count", wr_count - w0, FB_BYTES);
        chk("basic_queue", exp_q.size(), 0);
        chk("basic_dropped", frames_dropped, 0);
        chk("basic_busy_done", busy, 0);
        after_done("basic");

        // ack stall after byte 100 is issued
        key = 8'($urandom);
        w0 = wr_count;
        push_copy(FB_BYTES);
        pulse_fc();
        a = cyc;
        while (cyc < a + 102) tick();
        bus_ack = 1'b0;
        repeat (5) tick();
        bus_ack = 1'b1;
        wait_done("stall", d);
        chk("stall_latency", d - a, FB_BYTES + 7);
        chk("stall_count", wr_count - w0, FB_BYTES);
        chk("stall_queue", exp_q.size(), 0);
        after_done("stall");

        // back-to-back frames
        key = 8'($urandom);
        push_copy(FB_BYTES);
        push_copy(FB_BYTES);
        pulse_fc();
        a = cyc;
        while (cyc < a + 300) tick();
        pulse_fc();
        wait_done("b2b1", d);
        after_done("b2b1");
        chk("b2b_idle_gap", bus_request, 0);
        tick();
        chk("b2b_rereq", bus_request, 1);
        wait_done("b2b2", d);
        chk("b2b_queue", exp_q.size(), 0);
        chk("b2b_dropped", frames_dropped, 0);
        after_done("b2b2");

        // random ack pattern
        key = 8'($urandom);
        w0 = wr_count;
        push_copy(FB_BYTES);
        pulse_fc();
        d = -1;
        for (int t = 0; t < 5000; t++) begin
            bus_ack = ($urandom_range(0, 3) != 0);
            tick();
            if (copy_done === 1'b1) begin
                d = cyc;
                break;
            end
        end
        bus_ack = 1'b1;
        chk("rand_completed", (d >= 0), 1);
        chk("rand_count", wr_count - w0, FB_BYTES);
        chk("rand_queue", exp_q.size(), 0);
        after_done("rand");

        // overrun: three requests during one copy
        key = 8'($urandom);
        push_copy(FB_BYTES);
        push_copy(FB_BYTES);
        pulse_fc();
        a = cyc;
        while (cyc < a + 100) tick();
        pulse_fc();
        repeat (10) tick();
        pulse_fc();
        repeat (10) tick();
        pulse_fc();
        wait_done("ovr1", d);
        after_done("ovr1");
        wait_done("ovr2", d);
        chk("ovr_dropped", frames_dropped, 2);
        after_done("ovr2");

        // saturating burst
        push_copy(FB_BYTES);
        push_copy(FB_BYTES);
        pulse_fc();
        a = cyc;
        while (cyc < a + 50) tick();
        frame_complete = 1'b1;
        repeat (300) tick();
        frame_complete = 1'b0;
        wait_done("sat1", d);
        after_done("sat1");
        wait_done("sat2", d);
        chk("sat_dropped", frames_dropped, 255);
        chk("sat_queue", exp_q.size(), 0);
        after_done("sat2");

        // reset at byte 400
        key = 8'($urandom);
        push_copy(401);
        pulse_fc();
        a = cyc;
        while (cyc < a + 402) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_bus_request", bus_request, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dst_we", dst_we, 0);
        chk("mid_rst_dropped", frames_dropped, 0);
        chk("mid_rst_mem_address", mem_address, FB_BASE);
        chk("mid_rst_bank", display_bank, 0);
        chk("mid_rst_queue", exp_q.size(), 0);
        reset = 1'b0;
        wb_next = DB;
        disp_exp = 1'b0;
        repeat (3) tick();
        chk("mid_rst_pending_lost", bus_request, 0);

        key = 8'($urandom);
        w0 = wr_count;
        push_copy(FB_BYTES);
        pulse_fc();
        a = cyc;
        wait_done("restart", d);
        chk("restart_latency", d - a, FB_BYTES + 2);
        chk("restart_count", wr_count - w0, FB_BYTES);
        chk("restart_queue", exp_q.size(), 0);
        after_done("restart");

        // second copy after restart exercises the bank returning
        push_copy(FB_BYTES);
        pulse_fc();
        wait_done("final", d);
        chk("final_queue", exp_q.size(), 0);
        after_done("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
